// File: rtl/replica_pkg.sv
// Shared types and sizing for the replica annealing array.
// Holds the city count, distance word type, and the loader state
// that the top-level controller decodes.
package replica_pkg;

  localparam int city_num     = 8;
  localparam int city_num_log = 3;

  // Triangular address / row base / row counter width.
  localparam int tp_addr_w = city_num_log * 2 - 1;

  typedef logic [15:0]          distance_data_t;
  typedef logic [tp_addr_w-1:0] tp_addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } tp_load_state_t;

endpackage

// File: rtl/tp_dis_loader_if.sv
// Host stream in, distance RAM broadcast write out.
// The master modport is the host side; the slave modport is the loader.
interface tp_dis_loader_if
  import replica_pkg::*;
  ;

  logic           s_valid;
  distance_data_t s_data;
  logic           s_ready;
  logic           tp_dis_write;
  tp_addr_t       tp_dis_waddr;
  distance_data_t tp_dis_wdata;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  tp_dis_write,
    input  tp_dis_waddr,
    input  tp_dis_wdata
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output tp_dis_write,
    output tp_dis_waddr,
    output tp_dis_wdata
  );

endinterface

// File: rtl/tp_dis_loader.sv
// Loads the two-point distance table into every node's distance RAM.
// Accepts a packed lower-triangle stream or a full NxN row-major matrix
// and generates the triangular address i(i-1)/2 + j with adders only:
// the row base accumulates i on every row advance.
module tp_dis_loader
  import replica_pkg::*;
#(
  parameter int city = city_num
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             full_matrix,
  output logic             busy,
  output logic             done,
  tp_dis_loader_if.slave   bus
);

  localparam tp_addr_t last_idx = tp_addr_t'(city - 1);

  tp_load_state_t state_r;
  logic           full_r;
  tp_addr_t       i_r;
  tp_addr_t       j_r;
  tp_addr_t       rb_r;

  logic           accept_s;
  logic           row_end_s;
  logic           last_s;
  logic           write_due_s;
  tp_addr_t       addr_s;
  tp_addr_t       i_m1_s;

  assign accept_s = bus.s_valid & bus.s_ready;
  assign i_m1_s   = i_r - tp_addr_t'(1);
  assign addr_s   = rb_r + j_r;

  // Row end, last word and write qualification for the current (i, j).
  always_comb begin
    row_end_s   = 1'b0;
    write_due_s = 1'b0;
    if (full_r) begin
      row_end_s   = (j_r == last_idx);
      write_due_s = (j_r < i_r);
    end else begin
      row_end_s   = (j_r == i_m1_s);
      write_due_s = 1'b1;
    end
    last_s = (i_r == last_idx) & row_end_s;
  end

  // Load FSM: counters, row base and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r          <= IDLE;
      full_r           <= 1'b0;
      i_r              <= '0;
      j_r              <= '0;
      rb_r             <= '0;
      bus.s_ready      <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      bus.tp_dis_write <= 1'b0;
      bus.tp_dis_waddr <= '0;
      bus.tp_dis_wdata <= '0;
    end else begin
      done             <= 1'b0;
      bus.tp_dis_write <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= LOAD;
            full_r      <= full_matrix;
            i_r         <= full_matrix ? tp_addr_t'(0) : tp_addr_t'(1);
            j_r         <= '0;
            rb_r        <= '0;
            bus.s_ready <= 1'b1;
            busy        <= 1'b1;
          end
        end
        LOAD: begin
          if (accept_s) begin
            if (write_due_s) begin
              bus.tp_dis_write <= 1'b1;
              bus.tp_dis_waddr <= addr_s;
              bus.tp_dis_wdata <= bus.s_data;
            end
            if (last_s) begin
              state_r     <= IDLE;
              bus.s_ready <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end else if (row_end_s) begin
              // rb uses the pre-increment i: i(i-1)/2 + i = (i+1)i/2.
              j_r  <= '0;
              rb_r <= rb_r + i_r;
              i_r  <= i_r + tp_addr_t'(1);
            end else begin
              j_r <= j_r + tp_addr_t'(1);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          bus.s_ready <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tp_dis_loader.sv
// Directed bench for tp_dis_loader with three instances (N = 4, 5, 2).
// A negedge monitor logs every write and done pulse with its cycle number;
// each test task drives a load and compares against hand-computed values.
module tb_tp_dis_loader;
  import replica_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic st4, fm4, busy4, done4;
  logic st5, fm5, busy5, done5;
  logic st2, fm2, busy2, done2;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  tp_dis_loader_if b4 ();
  tp_dis_loader_if b5 ();
  tp_dis_loader_if b2 ();

  tp_dis_loader #(.city(4)) u4 (.clk(clk), .reset(reset), .start(st4), .full_matrix(fm4),
                                .busy(busy4), .done(done4), .bus(b4));
  tp_dis_loader #(.city(5)) u5 (.clk(clk), .reset(reset), .start(st5), .full_matrix(fm5),
                                .busy(busy5), .done(done5), .bus(b5));
  tp_dis_loader #(.city(2)) u2 (.clk(clk), .reset(reset), .start(st2), .full_matrix(fm2),
                                .busy(busy2), .done(done2), .bus(b2));

  always #5 clk = ~clk;

  // Edge counter used to timestamp stimulus and observed outputs.
  always @(posedge clk) cyc <= cyc + 1;

  tp_addr_t       wa4[$], wa5[$], wa2[$];
  distance_data_t wd4[$], wd5[$], wd2[$];
  int             wc4[$], wc5[$], wc2[$];
  int             dc4[$], dc5[$], dc2[$];

  // Log writes and done pulses of every instance.
  always @(negedge clk) begin
    if (b4.tp_dis_write) begin wa4.push_back(b4.tp_dis_waddr); wd4.push_back(b4.tp_dis_wdata); wc4.push_back(cyc); end
    if (b5.tp_dis_write) begin wa5.push_back(b5.tp_dis_waddr); wd5.push_back(b5.tp_dis_wdata); wc5.push_back(cyc); end
    if (b2.tp_dis_write) begin wa2.push_back(b2.tp_dis_waddr); wd2.push_back(b2.tp_dis_wdata); wc2.push_back(cyc); end
    if (done4) dc4.push_back(cyc);
    if (done5) dc5.push_back(cyc);
    if (done2) dc2.push_back(cyc);
  end

  task automatic clear_logs();
    wa4.delete(); wd4.delete(); wc4.delete(); dc4.delete();
    wa5.delete(); wd5.delete(); wc5.delete(); dc5.delete();
    wa2.delete(); wd2.delete(); wc2.delete(); dc2.delete();
  endtask

  task automatic set_in(input int sel, input logic v, input distance_data_t d);
    case (sel)
      4: begin b4.s_valid = v; b4.s_data = d; end
      5: begin b5.s_valid = v; b5.s_data = d; end
      default: begin b2.s_valid = v; b2.s_data = d; end
    endcase
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      4: return b4.s_ready;
      5: return b5.s_ready;
      default: return b2.s_ready;
    endcase
  endfunction

  // One-cycle start pulse; returns #1 after the sampling edge.
  task automatic start_load(input int sel, input logic fm);
    case (sel)
      4: begin st4 = 1'b1; fm4 = fm; end
      5: begin st5 = 1'b1; fm5 = fm; end
      default: begin st2 = 1'b1; fm2 = fm; end
    endcase
    @(posedge clk); #1;
    st4 = 1'b0; st5 = 1'b0; st2 = 1'b0;
  endtask

  // Present one word after 'gap' idle cycles; pres = cycle it was taken in.
  task automatic send(input int sel, input distance_data_t w, input int gap, output int pres);
    logic r;
    logic ok;
    set_in(sel, 1'b0, w);
    repeat (gap) begin @(posedge clk); #1; end
    set_in(sel, 1'b1, w);
    ok = 1'b0;
    pres = -1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      r = rdy(sel);
      pres = cyc;
      @(posedge clk); #1;
      ok = r;
    end
    set_in(sel, 1'b0, w);
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout inst=%0d word=%0d: s_ready never seen, required 1", sel, w);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (b4.s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready got %b want 0", b4.s_ready); end
    tests++; if (busy4 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy4); end
    tests++; if (done4 !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done4); end
    tests++; if (b4.tp_dis_write !== 1'b0) begin fails++; $display("FAIL reset_write got %b want 0", b4.tp_dis_write); end
    tests++; if (b4.tp_dis_waddr !== 5'd0) begin fails++; $display("FAIL reset_waddr got %0d want 0", b4.tp_dis_waddr); end
    tests++; if (b4.tp_dis_wdata !== 16'd0) begin fails++; $display("FAIL reset_wdata got %0d want 0", b4.tp_dis_wdata); end
  endtask

  task automatic test_triangle();
    int pres;
    clear_logs();
    start_load(4, 1'b0);
    tests++; if (b4.s_ready !== 1'b1) begin fails++; $display("FAIL tri_start_ready got %b want 1", b4.s_ready); end
    tests++; if (busy4 !== 1'b1) begin fails++; $display("FAIL tri_start_busy got %b want 1", busy4); end
    for (int k = 0; k < 6; k++) send(4, 16'(10 + k), 0, pres);
    @(negedge clk);
    tests++; if (b4.s_ready !== 1'b0 || busy4 !== 1'b0) begin
      fails++; $display("FAIL tri_end_idle got ready=%b busy=%b want 0 0", b4.s_ready, busy4); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (wa4.size() != 6) begin fails++; $display("FAIL tri_count got %0d want 6", wa4.size()); end
    else begin
      for (int k = 0; k < 6; k++) begin
        tests++; if (wa4[k] !== 5'(k) || wd4[k] !== 16'(10 + k)) begin
          fails++; $display("FAIL tri_write%0d got a=%0d d=%0d want a=%0d d=%0d", k, wa4[k], wd4[k], k, 10 + k); end
      end
      tests++; if (wc4[5] - wc4[0] != 5) begin fails++; $display("FAIL tri_spacing got %0d want 5", wc4[5] - wc4[0]); end
      tests++; if (dc4.size() != 1 || dc4[0] != wc4[5] || dc4[0] != pres + 1) begin
        fails++; $display("FAIL tri_done got n=%0d cyc=%0d want n=1 cyc=%0d", dc4.size(), dc4[0], pres + 1); end
    end
  endtask

  task automatic test_full();
    int pres;
    distance_data_t exp_d [6] = '{16'd16, 16'd32, 16'd33, 16'd48, 16'd49, 16'd50};
    clear_logs();
    start_load(4, 1'b1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) send(4, 16'(16 * i + j), 0, pres);
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (wa4.size() != 6) begin fails++; $display("FAIL full_count got %0d want 6", wa4.size()); end
    else begin
      for (int k = 0; k < 6; k++) begin
        tests++; if (wa4[k] !== 5'(k) || wd4[k] !== exp_d[k]) begin
          fails++; $display("FAIL full_write%0d got a=%0d d=%0d want a=%0d d=%0d", k, wa4[k], wd4[k], k, exp_d[k]); end
      end
      tests++; if (dc4.size() != 1 || dc4[0] != pres + 1 || wc4[5] >= dc4[0]) begin
        fails++; $display("FAIL full_done got n=%0d cyc=%0d want n=1 cyc=%0d after last write", dc4.size(), dc4[0], pres + 1); end
    end
    tests++; if (busy4 !== 1'b0) begin fails++; $display("FAIL full_busy_end got %b want 0", busy4); end
  endtask

  task automatic test_gaps();
    int pres;
    clear_logs();
    start_load(5, 1'b0);
    for (int k = 0; k < 10; k++) send(5, 16'(100 + k), k % 3, pres);
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (wa5.size() != 10) begin fails++; $display("FAIL gap_count got %0d want 10", wa5.size()); end
    else begin
      for (int k = 0; k < 10; k++) begin
        tests++; if (wa5[k] !== 5'(k) || wd5[k] !== 16'(100 + k)) begin
          fails++; $display("FAIL gap_write%0d got a=%0d d=%0d want a=%0d d=%0d", k, wa5[k], wd5[k], k, 100 + k); end
      end
      tests++; if (dc5.size() != 1 || dc5[0] != wc5[9]) begin
        fails++; $display("FAIL gap_done got n=%0d cyc=%0d want n=1 cyc=%0d", dc5.size(), dc5[0], wc5[9]); end
    end
  endtask

  task automatic test_start_mid();
    int pres;
    clear_logs();
    start_load(4, 1'b0);
    for (int k = 0; k < 3; k++) send(4, 16'(10 + k), 0, pres);
    start_load(4, 1'b1);
    fm4 = 1'b0;
    for (int k = 3; k < 6; k++) send(4, 16'(10 + k), 0, pres);
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (wa4.size() != 6) begin fails++; $display("FAIL mid_count got %0d want 6", wa4.size()); end
    else begin
      for (int k = 0; k < 6; k++) begin
        tests++; if (wa4[k] !== 5'(k) || wd4[k] !== 16'(10 + k)) begin
          fails++; $display("FAIL mid_write%0d got a=%0d d=%0d want a=%0d d=%0d", k, wa4[k], wd4[k], k, 10 + k); end
      end
      tests++; if (dc4.size() != 1 || dc4[0] != wc4[5]) begin
        fails++; $display("FAIL mid_done got n=%0d cyc=%0d want n=1 cyc=%0d", dc4.size(), dc4[0], wc4[5]); end
    end
  endtask

  task automatic test_reset_mid();
    int pres;
    clear_logs();
    start_load(4, 1'b0);
    for (int k = 0; k < 3; k++) send(4, 16'(10 + k), 0, pres);
    set_in(4, 1'b1, 16'd13);
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (b4.tp_dis_write !== 1'b0 || busy4 !== 1'b0 || b4.s_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_outputs got w=%b busy=%b ready=%b want 0 0 0", b4.tp_dis_write, busy4, b4.s_ready); end
    set_in(4, 1'b0, 16'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    tests++; if (wa4.size() != 3) begin fails++; $display("FAIL rstmid_partial got %0d writes want 3", wa4.size()); end
    clear_logs();
    start_load(4, 1'b0);
    for (int k = 0; k < 6; k++) send(4, 16'(20 + k), 0, pres);
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (wa4.size() != 6 || wa4[0] !== 5'd0 || wd4[0] !== 16'd20 || wa4[5] !== 5'd5 || wd4[5] !== 16'd25) begin
      fails++; $display("FAIL rstmid_reload got n=%0d a0=%0d d0=%0d want n=6 a0=0 d0=20", wa4.size(), wa4[0], wd4[0]); end
  endtask

  task automatic test_n2();
    int pres;
    clear_logs();
    start_load(2, 1'b0);
    send(2, 16'd77, 0, pres);
    @(negedge clk);
    tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL n2_busy got %b want 0", busy2); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (wa2.size() != 1 || wa2[0] !== 5'd0 || wd2[0] !== 16'd77) begin
      fails++; $display("FAIL n2_write got n=%0d a=%0d d=%0d want n=1 a=0 d=77", wa2.size(), wa2[0], wd2[0]); end
    tests++; if (dc2.size() != 1 || dc2[0] != pres + 1 || wc2[0] != pres + 1) begin
      fails++; $display("FAIL n2_done got n=%0d cyc=%0d want n=1 cyc=%0d", dc2.size(), dc2[0], pres + 1); end
  endtask

  task automatic test_back_to_back();
    int pres;
    clear_logs();
    start_load(4, 1'b0);
    for (int k = 0; k < 6; k++) send(4, 16'(30 + k), 0, pres);
    start_load(4, 1'b0);
    tests++; if (b4.s_ready !== 1'b1) begin fails++; $display("FAIL b2b_restart got ready=%b want 1", b4.s_ready); end
    for (int k = 0; k < 6; k++) send(4, 16'(40 + k), 0, pres);
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (wa4.size() != 12 || dc4.size() != 2) begin
      fails++; $display("FAIL b2b_count got w=%0d d=%0d want w=12 d=2", wa4.size(), dc4.size()); end
    else begin
      for (int k = 0; k < 12; k++) begin
        tests++; if (wa4[k] !== 5'(k % 6) || wd4[k] !== 16'((k < 6) ? 30 + k : 34 + k)) begin
          fails++; $display("FAIL b2b_write%0d got a=%0d d=%0d want a=%0d d=%0d", k, wa4[k], wd4[k], k % 6,
                            (k < 6) ? 30 + k : 34 + k); end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    st4 = 1'b0; fm4 = 1'b0; st5 = 1'b0; fm5 = 1'b0; st2 = 1'b0; fm2 = 1'b0;
    set_in(4, 1'b0, 16'd0); set_in(5, 1'b0, 16'd0); set_in(2, 1'b0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    test_triangle();
    test_full();
    test_gaps();
    test_start_mid();
    test_reset_mid();
    test_n2();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
